// File: rtl/tis_any_reader.sv
// tis_any_reader: multi-channel read port for a TIS node.
// Serves one read per accepted request from a specific channel, from ANY
// channel (fixed priority or round-robin), from the LAST channel won by ANY,
// or resolves it to NIL (returns 0 without touching any channel).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | ready for a request (req_ready = 1)
// WAIT  | request latched, waiting for the target/any channel valid
// RESP  | rsp_valid pulse, result on rsp_data/rsp_chan
module tis_any_reader #(
    parameter int CHANNELS = 4,
    parameter int DATA_W   = 11,
    parameter int RR_MODE  = 0,
    localparam int CW      = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [1:0]                 req_mode,
    input  logic [CW-1:0]              req_chan,
    input  logic [CHANNELS-1:0]        in_valid,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    output logic [CHANNELS-1:0]        in_ready,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_data,
    output logic [CW-1:0]              rsp_chan,
    output logic                       last_valid,
    output logic [CW-1:0]              last_chan
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [1:0] M_SPEC = 2'd0;
    localparam logic [1:0] M_ANY  = 2'd1;
    localparam logic [1:0] M_LAST = 2'd2;
    localparam logic [1:0] M_NIL  = 2'd3;

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic              req_nil;
    logic              any_q;
    logic [CW-1:0]     chan_q;
    logic [CW-1:0]     rr_ptr;
    logic              any_hit;
    logic [CW-1:0]     any_idx;
    logic [CW:0]       scan_idx;
    logic [CW-1:0]     sel_idx;
    logic              sel_hit;
    logic              xfer;
    logic [DATA_W-1:0] chan_data [CHANNELS];

    for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
        assign chan_data[k] = in_data[k*DATA_W +: DATA_W];
    end

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign req_nil = (req_mode == M_NIL)
                  || ((req_mode == M_SPEC) && (32'(req_chan) >= 32'(CHANNELS)))
                  || ((req_mode == M_LAST) && !last_valid);

    // ANY grant: scan channels starting at rr_ptr (round-robin) or 0 (fixed),
    // wrapping modulo CHANNELS; first valid channel wins.
    always_comb begin
        any_hit  = 1'b0;
        any_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            scan_idx = (RR_MODE != 0) ? ({1'b0, rr_ptr} + (CW+1)'(k)) : (CW+1)'(k);
            if (scan_idx >= (CW+1)'(CHANNELS)) begin
                scan_idx = scan_idx - (CW+1)'(CHANNELS);
            end
            if (!any_hit && in_valid[scan_idx[CW-1:0]]) begin
                any_hit = 1'b1;
                any_idx = scan_idx[CW-1:0];
            end
        end
    end

    // Specific and LAST reads share the latched channel; ANY uses the live grant.
    assign sel_idx = any_q ? any_idx : chan_q;
    assign sel_hit = any_q ? any_hit : in_valid[chan_q];
    assign xfer    = (state_q == ST_WAIT) && sel_hit;

    // One-hot consume strobe, only while waiting and only on the selected channel.
    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[sel_idx] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_d = req_nil ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (xfer) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request latch, result registers and ANY bookkeeping (LAST, rr_ptr).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_q      <= 1'b0;
            chan_q     <= '0;
            rsp_data   <= '0;
            rsp_chan   <= '0;
            last_valid <= 1'b0;
            last_chan  <= '0;
            rr_ptr     <= '0;
        end else begin
            if (accept) begin
                any_q  <= (req_mode == M_ANY);
                chan_q <= (req_mode == M_LAST) ? last_chan : req_chan;
                if (req_nil) begin
                    rsp_data <= '0;
                    rsp_chan <= '0;
                end
            end
            if (xfer) begin
                rsp_data <= chan_data[sel_idx];
                rsp_chan <= sel_idx;
                if (any_q) begin
                    last_valid <= 1'b1;
                    last_chan  <= any_idx;
                    rr_ptr     <= (any_idx == CW'(CHANNELS - 1)) ? '0 : any_idx + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tis_any_reader.sv
// Bench for tis_any_reader: a fixed-priority 4-channel instance and a
// round-robin 5-channel instance share stimulus; sel chooses which one is
// driven and observed. Expected results come from a small reference model.
module tb_tis_any_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic [1:0]  req_mode;
    logic [2:0]  req_chan;
    logic [4:0]  in_valid;
    logic [54:0] in_data;

    logic        a_req_ready, a_rsp_valid, a_last_valid;
    logic [3:0]  a_in_ready;
    logic [10:0] a_rsp_data;
    logic [1:0]  a_rsp_chan, a_last_chan;
    logic        b_req_ready, b_rsp_valid, b_last_valid;
    logic [4:0]  b_in_ready;
    logic [10:0] b_rsp_data;
    logic [2:0]  b_rsp_chan, b_last_chan;

    logic        o_req_ready, o_rsp_valid, o_last_valid;
    logic [4:0]  o_in_ready;
    logic [10:0] o_rsp_data;
    logic [2:0]  o_rsp_chan, o_last_chan;

    int n_vec = 0;
    int n_err = 0;

    // reference model: LAST register and round-robin pointer per instance
    int m_lv [2];
    int m_lc [2];
    int m_ptr[2];

    always #5 clk = ~clk;

    tis_any_reader #(.CHANNELS(4), .DATA_W(11), .RR_MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
        .req_mode(req_mode), .req_chan(req_chan[1:0]),
        .in_valid(in_valid[3:0]), .in_data(in_data[43:0]), .in_ready(a_in_ready),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_chan(a_rsp_chan),
        .last_valid(a_last_valid), .last_chan(a_last_chan)
    );

    tis_any_reader #(.CHANNELS(5), .DATA_W(11), .RR_MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid & sel), .req_ready(b_req_ready),
        .req_mode(req_mode), .req_chan(req_chan),
        .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_chan(b_rsp_chan),
        .last_valid(b_last_valid), .last_chan(b_last_chan)
    );

    assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign o_rsp_valid  = sel ? b_rsp_valid  : a_rsp_valid;
    assign o_last_valid = sel ? b_last_valid : a_last_valid;
    assign o_in_ready   = sel ? b_in_ready   : {1'b0, a_in_ready};
    assign o_rsp_data   = sel ? b_rsp_data   : a_rsp_data;
    assign o_rsp_chan   = sel ? b_rsp_chan   : {1'b0, a_rsp_chan};
    assign o_last_chan  = sel ? b_last_chan  : {1'b0, a_last_chan};

    function automatic int model_grant(input logic [4:0] iv, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (iv[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_lv[i] = 0; m_lc[i] = 0; m_ptr[i] = 0;
        end
    endtask

    task automatic set_word(input int k, input int v);
        logic [10:0] w;
        w = 11'(v);
        in_data[k*11 +: 11] = w;
    endtask

    // One complete read: issue, optional stall of the sources, response, return to idle.
    task automatic do_read(input int mode, input int chan, input int stall);
        int          n, tgt, g, start;
        bit          nil;
        logic [4:0]  saved, exp_rdy;
        logic [10:0] exp_d;
        n = sel ? 5 : 4;
        @(negedge clk);
        n_vec++;
        if (o_req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ready: got %b expected 1", o_req_ready);
        end
        req_valid = 1'b1;
        req_mode  = mode[1:0];
        req_chan  = chan[2:0];
        nil = (mode == 3) || (mode == 0 && chan >= n) || (mode == 2 && m_lv[sel] == 0);
        tgt = (mode == 2) ? m_lc[sel] : chan;
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (nil) begin
            @(negedge clk);
            n_vec++;
            if ({o_rsp_valid, o_rsp_data, o_rsp_chan, o_in_ready} !== {1'b1, 11'd0, 3'd0, 5'd0}) begin
                n_err++;
                $display("FAIL nil_resp: got v=%b d=%0d c=%0d rdy=%b expected v=1 d=0 c=0 rdy=0",
                         o_rsp_valid, $signed(o_rsp_data), o_rsp_chan, o_in_ready);
            end
        end else begin
            saved = in_valid;
            if (stall > 0) begin
                in_valid = '0;
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    n_vec++;
                    if ({o_rsp_valid, o_in_ready} !== 6'd0) begin
                        n_err++;
                        $display("FAIL stall_quiet: got v=%b rdy=%b expected v=0 rdy=0",
                                 o_rsp_valid, o_in_ready);
                    end
                end
                in_valid = saved;
                #1;
            end else begin
                @(negedge clk);
            end
            start = sel ? m_ptr[sel] : 0;
            if (mode == 1) g = model_grant(in_valid, start, n);
            else           g = in_valid[tgt] ? tgt : -1;
            exp_rdy = (g >= 0) ? (5'd1 << g) : 5'd0;
            exp_d   = (g >= 0) ? in_data[g*11 +: 11] : 11'd0;
            n_vec++;
            if ({o_req_ready, o_in_ready} !== {1'b0, exp_rdy}) begin
                n_err++;
                $display("FAIL wait_ready: got req_rdy=%b in_rdy=%b expected req_rdy=0 in_rdy=%b",
                         o_req_ready, o_in_ready, exp_rdy);
            end
            @(negedge clk);
            n_vec++;
            if ({o_rsp_valid, o_rsp_data, o_rsp_chan} !== {1'b1, exp_d, 3'(g)}) begin
                n_err++;
                $display("FAIL read_resp: got v=%b d=%0d c=%0d expected v=1 d=%0d c=%0d",
                         o_rsp_valid, $signed(o_rsp_data), o_rsp_chan, $signed(exp_d), g);
            end
            if (mode == 1 && g >= 0) begin
                m_lv[sel]  = 1;
                m_lc[sel]  = g;
                m_ptr[sel] = (g + 1) % n;
            end
        end
        @(negedge clk);
        n_vec++;
        if ({o_rsp_valid, o_req_ready, o_in_ready, o_last_valid, o_last_chan} !==
            {1'b0, 1'b1, 5'd0, m_lv[sel] != 0, 3'(m_lc[sel])}) begin
            n_err++;
            $display("FAIL post_read: got v=%b rdy=%b in_rdy=%b lv=%b lc=%0d expected v=0 rdy=1 in_rdy=0 lv=%0d lc=%0d",
                     o_rsp_valid, o_req_ready, o_in_ready, o_last_valid, o_last_chan, m_lv[sel], m_lc[sel]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_mode = '0; req_chan = '0;
        sel = 1'b0; in_valid = '0; in_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_vec++;
            if ({o_req_ready, o_in_ready, o_rsp_valid, o_rsp_data, o_rsp_chan, o_last_valid, o_last_chan} !==
                {1'b1, 5'd0, 1'b0, 11'd0, 3'd0, 1'b0, 3'd0}) begin
                n_err++;
                $display("FAIL reset_state: inst=%0d got rdy=%b in_rdy=%b v=%b d=%0d c=%0d lv=%b lc=%0d",
                         s, o_req_ready, o_in_ready, o_rsp_valid, o_rsp_data, o_rsp_chan, o_last_valid, o_last_chan);
            end
        end
        rst_n = 1'b1;
        sel = 1'b0;
    endtask

    task automatic test_last();
        sel = 1'b0;
        in_valid = 5'b00010; set_word(1, 123);
        do_read(2, 0, 0);                 // LAST before any ANY -> NIL
        in_valid = 5'b01010; set_word(1, 11); set_word(3, 44);
        do_read(1, 0, 0);                 // ANY grants chan 1
        in_valid = 5'b01011; set_word(0, -5); set_word(1, 999);
        do_read(2, 0, 0);                 // LAST replays chan 1 -> 999
    endtask

    task automatic test_specific();
        sel = 1'b0;
        in_valid = 5'b00100; set_word(2, 37);
        do_read(0, 2, 0);
    endtask

    task automatic test_fixed_any();
        sel = 1'b0;
        in_valid = 5'b01010; set_word(1, 5); set_word(3, -7);
        do_read(1, 0, 0);                 // lowest index -> 5
        in_valid[1] = 1'b0;               // channel 1 word consumed
        do_read(1, 0, 0);                 // -> -7 from chan 3
    endtask

    task automatic test_round_robin();
        sel = 1'b1;
        in_valid = 5'b01111;
        for (int k = 0; k < 5; k++) set_word(k, k * 10);
        for (int r = 0; r < 5; r++) do_read(1, 0, 0);   // 0,10,20,30 then wrap to 0
    endtask

    task automatic test_blocking();
        sel = 1'b0;
        in_valid = 5'b00001; set_word(0, 3);
        do_read(1, 0, 10);                // ANY blocked 10 cycles, then chan 0
        sel = 1'b1;
        in_valid = 5'b11111;
        do_read(0, 5, 0);                 // out of range -> NIL
        do_read(0, 7, 0);
        do_read(3, 1, 0);                 // NIL mode
        do_read(0, 4, 2);                 // highest legal channel, stalled
    endtask

    task automatic test_reset_mid_wait();
        sel = 1'b0;
        in_valid = '0;
        @(negedge clk);
        req_valid = 1'b1; req_mode = 2'd1; req_chan = '0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if ({o_rsp_valid, o_in_ready, o_req_ready} !== 7'd0) begin
                n_err++;
                $display("FAIL blocked_any: got v=%b in_rdy=%b rdy=%b expected all 0",
                         o_rsp_valid, o_in_ready, o_req_ready);
            end
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if ({o_req_ready, o_rsp_valid, o_last_valid, o_last_chan, o_in_ready} !==
                {1'b1, 1'b0, 1'b0, 3'd0, 5'd0}) begin
                n_err++;
                $display("FAIL reset_mid_wait: got rdy=%b v=%b lv=%b lc=%0d in_rdy=%b expected rdy=1 v=0 lv=0 lc=0 in_rdy=0",
                         o_req_ready, o_rsp_valid, o_last_valid, o_last_chan, o_in_ready);
            end
            @(negedge clk);
        end
        in_valid = 5'b00100; set_word(2, 37);
        do_read(0, 2, 0);
    endtask

    task automatic test_random();
        int n, mode, chan, stall;
        logic [4:0] mask;
        for (int i = 0; i < 200; i++) begin
            sel  = $urandom_range(1);
            n    = sel ? 5 : 4;
            mask = sel ? 5'b11111 : 5'b01111;
            mode = $urandom_range(3);
            chan = $urandom_range(sel ? 7 : 3);
            in_valid = 5'($urandom_range(31));
            for (int k = 0; k < 5; k++) set_word(k, int'($urandom_range(1998)) - 999);
            if (mode == 0 && chan < n) in_valid[chan] = 1'b1;
            if (mode == 2 && m_lv[sel] != 0) in_valid[m_lc[sel]] = 1'b1;
            if (mode == 1 && (in_valid & mask) == 5'd0) in_valid[$urandom_range(n - 1)] = 1'b1;
            stall = ($urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
            do_read(mode, chan, stall);
        end
    endtask

    initial begin
        test_reset();
        test_last();
        test_specific();
        test_fixed_any();
        test_round_robin();
        test_blocking();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
